// File: rtl/toom_8_splitting.sv
// Operand-splitting front end of the Toom-8 1024x1024 multiplier: signed limb views of X and Y
// plus a registered reference product recombined from 128x128 limb partial products.
module toom_8_splitting (
  input  logic          clk,
  input  logic          rst,
  input  logic [1023:0] X,
  input  logic [1023:0] Y,
  output logic [2047:0] product,
  output logic [128:0]  A_chunk0,
  output logic [128:0]  A_chunk1,
  output logic [128:0]  A_chunk2,
  output logic [128:0]  A_chunk3,
  output logic [128:0]  A_chunk4,
  output logic [128:0]  A_chunk5,
  output logic [128:0]  A_chunk6,
  output logic [128:0]  A_chunk7,
  output logic [128:0]  B_chunk0,
  output logic [128:0]  B_chunk1,
  output logic [128:0]  B_chunk2,
  output logic [128:0]  B_chunk3,
  output logic [128:0]  B_chunk4,
  output logic [128:0]  B_chunk5,
  output logic [128:0]  B_chunk6,
  output logic [128:0]  B_chunk7
);

  localparam int unsigned LIMB_W    = 128;
  localparam int unsigned NUM_LIMBS = 8;
  localparam int unsigned PP_W      = 2 * LIMB_W;
  localparam int unsigned NUM_DIAG  = 2 * NUM_LIMBS - 1;
  // A diagonal sums at most eight 256-bit products, so three guard bits suffice.
  localparam int unsigned DIAG_W    = PP_W + 3;
  localparam int unsigned PROD_W    = 2 * LIMB_W * NUM_LIMBS;

  logic [LIMB_W-1:0] x_limb  [NUM_LIMBS];
  logic [LIMB_W-1:0] y_limb  [NUM_LIMBS];
  logic [LIMB_W:0]   a_chunk [NUM_LIMBS];
  logic [LIMB_W:0]   b_chunk [NUM_LIMBS];
  logic [PP_W-1:0]   pp      [NUM_LIMBS][NUM_LIMBS];
  logic [DIAG_W-1:0] diag    [NUM_DIAG];
  logic [PROD_W-1:0] product_d;

  for (genvar i = 0; i < NUM_LIMBS; i++) begin : g_limb
    assign x_limb[i]  = X[i*LIMB_W +: LIMB_W];
    assign y_limb[i]  = Y[i*LIMB_W +: LIMB_W];
    assign a_chunk[i] = {x_limb[i][LIMB_W-1], x_limb[i]};
    assign b_chunk[i] = {y_limb[i][LIMB_W-1], y_limb[i]};
  end

  assign A_chunk0 = a_chunk[0];
  assign A_chunk1 = a_chunk[1];
  assign A_chunk2 = a_chunk[2];
  assign A_chunk3 = a_chunk[3];
  assign A_chunk4 = a_chunk[4];
  assign A_chunk5 = a_chunk[5];
  assign A_chunk6 = a_chunk[6];
  assign A_chunk7 = a_chunk[7];
  assign B_chunk0 = b_chunk[0];
  assign B_chunk1 = b_chunk[1];
  assign B_chunk2 = b_chunk[2];
  assign B_chunk3 = b_chunk[3];
  assign B_chunk4 = b_chunk[4];
  assign B_chunk5 = b_chunk[5];
  assign B_chunk6 = b_chunk[6];
  assign B_chunk7 = b_chunk[7];

  // Unsigned limb products; the raw limbs are used, never the sign-extended chunks.
  for (genvar i = 0; i < NUM_LIMBS; i++) begin : g_pp_row
    for (genvar j = 0; j < NUM_LIMBS; j++) begin : g_pp_col
      assign pp[i][j] = PP_W'(x_limb[i]) * PP_W'(y_limb[j]);
    end
  end

  // Products sharing weight 2^(128*k) are summed first, so the wide adder sees only 15 terms.
  always_comb begin
    for (int k = 0; k < NUM_DIAG; k++) begin
      diag[k] = '0;
      for (int i = 0; i < NUM_LIMBS; i++) begin
        for (int j = 0; j < NUM_LIMBS; j++) begin
          if (i + j == k) begin
            diag[k] = diag[k] + DIAG_W'(pp[i][j]);
          end
        end
      end
    end
  end

  always_comb begin
    product_d = '0;
    for (int k = 0; k < NUM_DIAG; k++) begin
      product_d = product_d + (PROD_W'(diag[k]) << (k * int'(LIMB_W)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      product <= '0;
    end else begin
      product <= product_d;
    end
  end

endmodule

// File: tb/tb_toom_8_splitting.sv
// Directed bench for toom_8_splitting: limb split, product latency, boundaries and async reset.
module tb_toom_8_splitting;

  logic          clk;
  logic          rst;
  logic [1023:0] X;
  logic [1023:0] Y;
  logic [2047:0] product;
  logic [128:0]  A_chunk0, A_chunk1, A_chunk2, A_chunk3, A_chunk4, A_chunk5, A_chunk6, A_chunk7;
  logic [128:0]  B_chunk0, B_chunk1, B_chunk2, B_chunk3, B_chunk4, B_chunk5, B_chunk6, B_chunk7;

  int unsigned n_cmp;
  int unsigned n_fail;

  logic [2047:0] exp_p;
  logic [1023:0] hi_half;
  logic [128:0]  ones129;
  logic [127:0]  lmin;
  logic [127:0]  lmax;

  toom_8_splitting dut (
    .clk      (clk),
    .rst      (rst),
    .X        (X),
    .Y        (Y),
    .product  (product),
    .A_chunk0 (A_chunk0),
    .A_chunk1 (A_chunk1),
    .A_chunk2 (A_chunk2),
    .A_chunk3 (A_chunk3),
    .A_chunk4 (A_chunk4),
    .A_chunk5 (A_chunk5),
    .A_chunk6 (A_chunk6),
    .A_chunk7 (A_chunk7),
    .B_chunk0 (B_chunk0),
    .B_chunk1 (B_chunk1),
    .B_chunk2 (B_chunk2),
    .B_chunk3 (B_chunk3),
    .B_chunk4 (B_chunk4),
    .B_chunk5 (B_chunk5),
    .B_chunk6 (B_chunk6),
    .B_chunk7 (B_chunk7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    X   = '1;
    Y   = '1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (product !== '0) begin
      n_fail++;
      $display("FAIL reset_async: product lo=%h hi=%h, required 0", product[127:0],
               product[2047:1920]);
    end
    n_cmp++;
    if (A_chunk0 !== ones129) begin
      n_fail++;
      $display("FAIL reset_a_chunk0: got %h, required %h", A_chunk0, ones129);
    end
    n_cmp++;
    if (A_chunk7 !== ones129) begin
      n_fail++;
      $display("FAIL reset_a_chunk7: got %h, required %h", A_chunk7, ones129);
    end
    n_cmp++;
    if (B_chunk3 !== ones129) begin
      n_fail++;
      $display("FAIL reset_b_chunk3: got %h, required %h", B_chunk3, ones129);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (product !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: product lo=%h, required 0", product[127:0]);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_split_vec1();
    @(negedge clk);
    X = {lmin + 128'd1, lmax, lmin + 128'd2, lmax - 128'd1,
         lmin + 128'd3, lmax - 128'd2, lmin + 128'd4, lmax - 128'd3};
    #1;
    n_cmp++;
    if (A_chunk0 !== {1'b0, lmax - 128'd3}) begin
      n_fail++;
      $display("FAIL split1_a0: got %h, required %h", A_chunk0, {1'b0, lmax - 128'd3});
    end
    n_cmp++;
    if (A_chunk1 !== {1'b1, lmin + 128'd4}) begin
      n_fail++;
      $display("FAIL split1_a1: got %h, required %h", A_chunk1, {1'b1, lmin + 128'd4});
    end
    n_cmp++;
    if (A_chunk6 !== {1'b0, lmax}) begin
      n_fail++;
      $display("FAIL split1_a6: got %h, required %h", A_chunk6, {1'b0, lmax});
    end
    n_cmp++;
    if (A_chunk7 !== {1'b1, lmin + 128'd1}) begin
      n_fail++;
      $display("FAIL split1_a7: got %h, required %h", A_chunk7, {1'b1, lmin + 128'd1});
    end
  endtask

  task automatic test_split_vec2();
    @(negedge clk);
    Y = {lmax, lmin + 128'd1, lmax - 128'd1, lmin + 128'd2,
         lmax - 128'd2, lmin + 128'd3, lmax - 128'd3, lmin + 128'd4};
    #1;
    n_cmp++;
    if (B_chunk0 !== {1'b1, lmin + 128'd4}) begin
      n_fail++;
      $display("FAIL split2_b0: got %h, required %h", B_chunk0, {1'b1, lmin + 128'd4});
    end
    n_cmp++;
    if (B_chunk7 !== {1'b0, lmax}) begin
      n_fail++;
      $display("FAIL split2_b7: got %h, required %h", B_chunk7, {1'b0, lmax});
    end
    n_cmp++;
    if (B_chunk2 !== {1'b1, lmin + 128'd3}) begin
      n_fail++;
      $display("FAIL split2_b2: got %h, required %h", B_chunk2, {1'b1, lmin + 128'd3});
    end
  endtask

  task automatic test_small();
    @(negedge clk);
    X = 1024'd1;
    Y = 1024'd1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (product !== 2048'd1) begin
      n_fail++;
      $display("FAIL small_one: product lo=%h, required 1", product[127:0]);
    end
    @(negedge clk);
    X = 1024'd1 << 128;
    Y = 1024'd1 << 128;
    exp_p = 2048'd1 << 256;
    @(posedge clk);
    #1;
    n_cmp++;
    if (product !== exp_p) begin
      n_fail++;
      $display("FAIL small_cross_limb: product[383:0]=%h, required %h", product[383:0],
               exp_p[383:0]);
    end
  endtask

  task automatic test_max();
    @(negedge clk);
    X = '1;
    Y = '1;
    hi_half    = '1;
    hi_half[0] = 1'b0;
    exp_p = {hi_half, 1024'd1};
    @(posedge clk);
    #1;
    n_cmp++;
    if (product !== exp_p) begin
      n_fail++;
      $display("FAIL max_product: lo=%h mid=%h hi=%h, required lo=%h mid=%h hi=%h",
               product[127:0], product[1151:1024], product[2047:1920],
               exp_p[127:0], exp_p[1151:1024], exp_p[2047:1920]);
    end
  endtask

  task automatic test_zero();
    @(negedge clk);
    X = '0;
    Y = '1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (product !== '0) begin
      n_fail++;
      $display("FAIL zero_x: product lo=%h, required 0", product[127:0]);
    end
    @(negedge clk);
    X = {lmax, lmin, lmax, lmin, lmax, lmin, lmax, lmin};
    Y = '0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (product !== '0) begin
      n_fail++;
      $display("FAIL zero_y: product lo=%h, required 0", product[127:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [1023:0] xs [4];
    logic [1023:0] ys [4];
    logic [2047:0] es [4];
    xs[0] = 1024'd3;                       ys[0] = 1024'd5;
    es[0] = 2048'd15;
    xs[1] = 1024'd1 << 1023;               ys[1] = 1024'd2;
    es[1] = 2048'd1 << 1024;
    xs[2] = (1024'd1 << 512) + 1024'd1;    ys[2] = (1024'd1 << 512) - 1024'd1;
    es[2] = (2048'd1 << 1024) - 2048'd1;
    xs[3] = (1024'd1 << 128) - 1024'd1;    ys[3] = (1024'd1 << 128) + 1024'd1;
    es[3] = (2048'd1 << 256) - 2048'd1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      X = xs[k];
      Y = ys[k];
      if (k == 0) begin
        #1;
        n_cmp++;
        if (product !== '0) begin
          n_fail++;
          $display("FAIL b2b_latency: product lo=%h before edge, required 0", product[127:0]);
        end
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (product !== es[k]) begin
        n_fail++;
        $display("FAIL b2b_pair%0d: lo=%h hi=%h, required lo=%h hi=%h", k, product[127:0],
                 product[1151:1024], es[k][127:0], es[k][1151:1024]);
      end
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    X = 1024'd3;
    Y = 1024'd5;
    @(posedge clk);
    #1;
    n_cmp++;
    if (product !== 2048'd15) begin
      n_fail++;
      $display("FAIL midrst_pre: product lo=%h, required f", product[127:0]);
    end
    @(negedge clk);
    X   = 1024'd7;
    Y   = 1024'd11;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (product !== '0) begin
      n_fail++;
      $display("FAIL midrst_async: product lo=%h, required 0", product[127:0]);
    end
    n_cmp++;
    if (A_chunk0 !== 129'd7) begin
      n_fail++;
      $display("FAIL midrst_chunk_track: A_chunk0 %h, required 7", A_chunk0);
    end
    #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (product !== '0) begin
      n_fail++;
      $display("FAIL midrst_release: product lo=%h, required 0", product[127:0]);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (product !== 2048'd77) begin
      n_fail++;
      $display("FAIL midrst_reload: product lo=%h, required 4d", product[127:0]);
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    rst     = 1'b0;
    X       = '0;
    Y       = '0;
    ones129 = '1;
    lmin    = {1'b1, 127'd0};
    lmax    = {1'b0, {127{1'b1}}};
    test_reset();
    test_split_vec1();
    test_split_vec2();
    test_small();
    test_max();
    test_zero();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/toom_8_splitting.md
Name: toom_8_splitting

Overview:
- Operand-splitting front end of the Toom-8 1024x1024 multiplier.
- Splits each 1024-bit operand X, Y into eight 128-bit limbs and exposes each limb sign-extended to 129 bits for the downstream Toom evaluation stage.
- Also produces a registered full-width unsigned product X*Y, recombined from limb partial products, as the golden result for the Toom datapath.

Parameters:
- LIMB_W, 128, limb width in bits; fixed, not overridable.
- NUM_LIMBS, 8, number of limbs (Toom-8); fixed, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- X  input  1024  operand A, unsigned vector
- Y  input  1024  operand B, unsigned vector
- product  output  2048  registered unsigned X*Y
- A_chunk0..A_chunk7  output  129 each  sign-extended limbs of X
- B_chunk0..B_chunk7  output  129 each  sign-extended limbs of Y

Behaviour:
- Limb mapping: limb i = X[128*i+127 : 128*i]. Chunk0 is the least-significant limb, chunk7 the most-significant. Same mapping for Y and B_chunk.
- Chunk format: A_chunk_i = {X[128*i+127], limb i}. Bit 128 replicates limb bit 127, so each limb is a signed 128-bit value in two's complement. Identical rule for B_chunk_i.
- Chunk timing: chunks are purely combinational from X and Y. Zero latency, unaffected by clk and rst.
- Product datapath:
  - Form the 64 unsigned 128x128 partial products P(i,j) = limbX_i * limbY_j, each 256 bits.
  - Sum all P(i,j) shifted left by 128*(i+j) into a 2048-bit accumulator. Raw limbs are used, not the sign-extended chunks.
  - The result equals the exact unsigned X*Y. It never overflows 2048 bits, so there is no truncation.
- Product register: the sum is registered into product on every rising clk edge. Latency is 1 cycle: the value sampled at edge N appears after edge N.
- Reset: rst high clears product to 0 immediately, without waiting for a clock edge. product holds 0 while rst is high and loads on the first rising edge after rst deasserts.
- Reset mid-operation: an in-flight result is discarded with no partial state. Chunk outputs keep tracking X and Y throughout reset.
- There is no handshake or valid signal. Inputs are sampled every cycle, and the output is a continuous pipeline of depth 1.
- Boundary cases:
  - X=0 or Y=0 gives product 0.
  - All-ones operands give the maximum product without wrap.
  - A limb with MSB=1 always has chunk bit 128 = 1.

Test Plan:
- Reset: assert rst with X=Y=all-ones -> product=0 asynchronously, before any clock edge. All chunks are still driven: A_chunk_i = 129'h1_FFFF...FFFF (all ones).
- Signed split, vector 1:
  - Stimulus X = 8000..0001_7FFF..FFFF_8000..0002_7FFF..FFFE_8000..0003_7FFF..FFFD_8000..0004_7FFF..FFFC (128-bit limbs, MSB limb first).
  - Required: A_chunk0 = 0_7FFF..FFFC and A_chunk1 = 1_8000..0004, in the same delta as X changes.
  - Required: A_chunk6 = 0_7FFF..FFFF and A_chunk7 = 1_8000..0001.
- Signed split, vector 2:
  - Stimulus Y = 7FFF..FFFF_8000..0001_7FFF..FFFE_8000..0002_7FFF..FFFD_8000..0003_7FFF..FFFC_8000..0004.
  - Required: B_chunk0 = 1_8000..0004 and B_chunk7 = 0_7FFF..FFFF.
- Small product:
  - X=1, Y=1 -> product=1 one edge later.
  - X=2^128, Y=2^128 -> product=2^256, i.e. bit 256 only, exercising the cross-limb shift.
- Max product:
  - X=Y=2^1024-1 -> product = 2^2048 - 2^1025 + 1.
  - Upper 1024 bits are all ones except bit 1024 = 0; lower 1024 bits equal 1.
- Pipelining and mid-run reset:
  - Change X, Y on consecutive edges -> product tracks each pair with exactly 1-cycle lag.
  - Pulse rst between two edges -> product=0 immediately, then the next edge loads the current X*Y.
